// File: rtl/fir_stream_v2.sv
// fir_stream_v2: runtime-configurable N-tap signed FIR, AXI-lite configured, AXI-stream in/out.
// One product per cycle over a circular sample buffer; shift/saturate applied when a result is produced.
module fir_stream_v2 #(
   parameter int pADDR_WIDTH = 12,
   parameter int pDATA_WIDTH = 32,
   parameter int pTAP_MAX    = 32,
   parameter int pTAP_AW     = 5
) (
   input  logic                   axis_clk,
   input  logic                   axis_rst,
   input  logic                   awvalid,
   output logic                   awready,
   input  logic [pADDR_WIDTH-1:0] awaddr,
   input  logic                   wvalid,
   output logic                   wready,
   input  logic [pDATA_WIDTH-1:0] wdata,
   input  logic                   arvalid,
   output logic                   arready,
   input  logic [pADDR_WIDTH-1:0] araddr,
   output logic                   rvalid,
   input  logic                   rready,
   output logic [pDATA_WIDTH-1:0] rdata,
   input  logic                   ss_tvalid,
   input  logic [pDATA_WIDTH-1:0] ss_tdata,
   input  logic                   ss_tlast,
   output logic                   ss_tready,
   output logic                   sm_tvalid,
   output logic [pDATA_WIDTH-1:0] sm_tdata,
   output logic                   sm_tlast,
   input  logic                   sm_tready
);

   localparam int W  = pDATA_WIDTH;
   localparam int AW = 2*pDATA_WIDTH + pTAP_AW;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_CLR  = 3'd1;
   localparam logic [2:0] S_WAIT = 3'd2;
   localparam logic [2:0] S_MAC  = 3'd3;
   localparam logic [2:0] S_OUT  = 3'd4;
   localparam logic [2:0] S_DONE = 3'd5;

   localparam logic [pADDR_WIDTH-1:0] A_CTRL   = pADDR_WIDTH'(32'h00);
   localparam logic [pADDR_WIDTH-1:0] A_LEN    = pADDR_WIDTH'(32'h10);
   localparam logic [pADDR_WIDTH-1:0] A_NTAP   = pADDR_WIDTH'(32'h14);
   localparam logic [pADDR_WIDTH-1:0] A_SCALE  = pADDR_WIDTH'(32'h18);
   localparam logic [pADDR_WIDTH-1:0] TAP_BASE = pADDR_WIDTH'(32'h80);
   localparam logic [pADDR_WIDTH-1:0] TAP_END  = pADDR_WIDTH'(128 + 4*pTAP_MAX);

   localparam logic [W-1:0] Y_MAX = {1'b0, {(W-1){1'b1}}};
   localparam logic [W-1:0] Y_MIN = {1'b1, {(W-1){1'b0}}};

   logic [2:0]             r_state;
   logic                   r_aw_held, r_w_held;
   logic [pADDR_WIDTH-1:0] r_awaddr;
   logic [W-1:0]           r_wdata;
   logic                   r_rvalid;
   logic [W-1:0]           r_rdata;
   logic                   r_ap_start, r_ap_done, r_early;
   logic [31:0]            r_len, r_ntap;
   logic [5:0]             r_sh;
   logic                   r_sat;
   logic signed [W-1:0]    r_h [pTAP_MAX];
   logic signed [W-1:0]    r_x [pTAP_MAX];
   logic [pTAP_AW-1:0]     r_ptr;
   logic [pTAP_AW:0]       r_k;
   logic [31:0]            r_cnt;
   logic                   r_xlast;
   logic signed [AW-1:0]   r_acc;
   logic [W-1:0]           r_tdata;
   logic                   r_tlast;

   logic                   w_idle, w_commit, w_start, w_rd_fire;
   logic                   w_wtap_hit, w_rtap_hit;
   logic [pADDR_WIDTH-1:0] w_wtap_off, w_rtap_off;
   logic [pTAP_AW-1:0]     w_wtap_idx, w_rtap_idx, w_xidx;
   logic [pTAP_AW:0]       w_ntap_eff;
   logic signed [2*W-1:0]  w_prod;
   logic signed [AW-1:0]   w_acc_nxt, w_shifted;
   logic                   w_hi_ok;
   logic [W-1:0]           w_y, w_rd;

   assign awready   = !r_aw_held;
   assign wready    = !r_w_held;
   assign arready   = !r_rvalid;
   assign rvalid    = r_rvalid;
   assign rdata     = r_rdata;
   assign ss_tready = (r_state == S_WAIT);
   assign sm_tvalid = (r_state == S_OUT);
   assign sm_tdata  = r_tdata;
   assign sm_tlast  = r_tlast;

   assign w_idle    = (r_state == S_IDLE);
   assign w_commit  = r_aw_held && r_w_held;
   assign w_start   = w_commit && (r_awaddr == A_CTRL) && r_wdata[0] && w_idle;
   assign w_rd_fire = arvalid && !r_rvalid;

   assign w_wtap_off = r_awaddr - TAP_BASE;
   assign w_wtap_hit = (r_awaddr >= TAP_BASE) && (r_awaddr < TAP_END) && (r_awaddr[1:0] == 2'b00);
   assign w_wtap_idx = pTAP_AW'(w_wtap_off >> 2);
   assign w_rtap_off = araddr - TAP_BASE;
   assign w_rtap_hit = (araddr >= TAP_BASE) && (araddr < TAP_END) && (araddr[1:0] == 2'b00);
   assign w_rtap_idx = pTAP_AW'(w_rtap_off >> 2);

   // A zero tap count still runs one product; oversize counts use the whole buffer.
   always_comb begin
      w_ntap_eff = r_ntap[pTAP_AW:0];
      if (r_ntap == 32'd0)                  w_ntap_eff = (pTAP_AW+1)'(1);
      else if (r_ntap > 32'(pTAP_MAX))      w_ntap_eff = (pTAP_AW+1)'(pTAP_MAX);
   end

   assign w_xidx    = r_ptr - r_k[pTAP_AW-1:0];
   assign w_prod    = (2*W)'(r_h[r_k[pTAP_AW-1:0]]) * (2*W)'(r_x[w_xidx]);
   assign w_acc_nxt = r_acc + AW'(w_prod);
   assign w_shifted = w_acc_nxt >>> r_sh;
   assign w_hi_ok   = (&w_shifted[AW-1:W-1]) || !(|w_shifted[AW-1:W-1]);
   assign w_y       = (r_sat && !w_hi_ok) ? (w_shifted[AW-1] ? Y_MIN : Y_MAX) : w_shifted[W-1:0];

   always_comb begin
      w_rd = '0;
      if (araddr == A_CTRL)
         w_rd = W'({r_early, sm_tvalid, ss_tready, 1'b0, w_idle, r_ap_done, r_ap_start});
      else if (araddr == A_LEN)   w_rd = r_len;
      else if (araddr == A_NTAP)  w_rd = r_ntap;
      else if (araddr == A_SCALE) w_rd = W'({r_sat, 2'b00, r_sh});
      else if (w_rtap_hit)        w_rd = r_h[w_rtap_idx];
   end

   // AXI-lite channels and configuration registers
   always_ff @(posedge axis_clk) begin
      if (axis_rst) begin
         r_aw_held <= 1'b0;
         r_w_held  <= 1'b0;
         r_awaddr  <= '0;
         r_wdata   <= '0;
         r_rvalid  <= 1'b0;
         r_rdata   <= '0;
         r_len     <= '0;
         r_ntap    <= 32'd1;
         r_sh      <= '0;
         r_sat     <= 1'b0;
         for (int i = 0; i < pTAP_MAX; i++) r_h[i] <= '0;
      end else begin
         if (awvalid && !r_aw_held) begin
            r_aw_held <= 1'b1;
            r_awaddr  <= awaddr;
         end
         if (wvalid && !r_w_held) begin
            r_w_held <= 1'b1;
            r_wdata  <= wdata;
         end
         if (w_commit) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            if (w_idle) begin
               if (r_awaddr == A_LEN)       r_len  <= r_wdata;
               else if (r_awaddr == A_NTAP) r_ntap <= r_wdata;
               else if (r_awaddr == A_SCALE) begin
                  r_sh  <= r_wdata[5:0];
                  r_sat <= r_wdata[8];
               end
               else if (w_wtap_hit)         r_h[w_wtap_idx] <= r_wdata;
            end
         end
         if (w_rd_fire) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rd;
         end else if (r_rvalid && rready) begin
            r_rvalid <= 1'b0;
         end
      end
   end

   // Run control and datapath
   always_ff @(posedge axis_clk) begin
      if (axis_rst) begin
         r_state    <= S_IDLE;
         r_ap_start <= 1'b0;
         r_ap_done  <= 1'b0;
         r_early    <= 1'b0;
         r_ptr      <= '0;
         r_k        <= '0;
         r_cnt      <= '0;
         r_xlast    <= 1'b0;
         r_acc      <= '0;
         r_tdata    <= '0;
         r_tlast    <= 1'b0;
         for (int i = 0; i < pTAP_MAX; i++) r_x[i] <= '0;
      end else begin
         r_ap_start <= w_start;
         if (w_start) begin
            r_ap_done <= 1'b0;
            r_early   <= 1'b0;
         end
         if (w_rd_fire && araddr == A_CTRL) r_ap_done <= 1'b0;
         case (r_state)
            S_IDLE: if (w_start) r_state <= (r_len == 32'd0) ? S_DONE : S_CLR;
            S_CLR: begin
               for (int i = 0; i < pTAP_MAX; i++) r_x[i] <= '0;
               r_ptr   <= '0;
               r_cnt   <= '0;
               r_early <= 1'b0;
               r_state <= S_WAIT;
            end
            S_WAIT: if (ss_tvalid) begin
               r_x[r_ptr] <= ss_tdata;
               r_xlast    <= ss_tlast;
               r_acc      <= '0;
               r_k        <= '0;
               r_state    <= S_MAC;
            end
            S_MAC: begin
               r_acc <= w_acc_nxt;
               r_k   <= r_k + (pTAP_AW+1)'(1);
               if (r_k == w_ntap_eff - (pTAP_AW+1)'(1)) begin
                  r_tdata <= w_y;
                  r_tlast <= (r_cnt == r_len - 32'd1) || r_xlast;
                  r_state <= S_OUT;
               end
            end
            S_OUT: if (sm_tready) begin
               r_cnt <= r_cnt + 32'd1;
               r_ptr <= r_ptr + pTAP_AW'(1);
               if (r_xlast && (r_cnt < r_len - 32'd1)) r_early <= 1'b1;
               r_state <= r_tlast ? S_DONE : S_WAIT;
            end
            S_DONE: begin
               r_ap_done <= 1'b1;
               r_state   <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fir_stream_v2.sv
// Directed bench for fir_stream_v2: a plain-arithmetic FIR model predicts every output beat,
// with literal values pinning the model on selected beats and status words.
module tb_fir_stream_v2;

   logic        clk = 1'b0;
   logic        rst;
   logic        awvalid, awready, wvalid, wready, arvalid, arready, rvalid, rready;
   logic [11:0] awaddr, araddr;
   logic [31:0] wdata, rdata;
   logic        ss_tvalid, ss_tlast, ss_tready, sm_tvalid, sm_tlast, sm_tready;
   logic [31:0] ss_tdata, sm_tdata;

   always #5 clk = ~clk;

   fir_stream_v2 dut (
      .axis_clk(clk), .axis_rst(rst),
      .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
      .wvalid(wvalid), .wready(wready), .wdata(wdata),
      .arvalid(arvalid), .arready(arready), .araddr(araddr),
      .rvalid(rvalid), .rready(rready), .rdata(rdata),
      .ss_tvalid(ss_tvalid), .ss_tdata(ss_tdata), .ss_tlast(ss_tlast), .ss_tready(ss_tready),
      .sm_tvalid(sm_tvalid), .sm_tdata(sm_tdata), .sm_tlast(sm_tlast), .sm_tready(sm_tready)
   );

   typedef struct { logic [31:0] d; logic l; } beat_t;

   localparam logic signed [127:0] LIM_HI = 128'sh7fffffff;
   localparam logic signed [127:0] LIM_LO = -128'sh80000000;

   int errs = 0, checks = 0, cyc = 0, xr_cnt = 0;
   bit rdy_rand = 0;
   logic signed [31:0] m_h [32];
   logic [31:0] m_ntap, m_len;
   int          m_sh;
   bit          m_sat;
   logic signed [31:0] m_hist[$];
   beat_t       expq[$];
   logic [31:0] rx[$];
   int          acc_q[$], rise_q[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tmo(input string nm);
      checks++;
      errs++;
      $display("FAIL %s: timed out waiting on DUT", nm);
   endtask

   // y[n] = sum over k < effective tap count of h[k]*x[n-k], history before the run is zero
   function automatic logic [31:0] model_y();
      logic signed [127:0] acc, a, b;
      int n, nt;
      acc = '0;
      n = m_hist.size() - 1;
      nt = (m_ntap == 0) ? 1 : ((m_ntap > 32) ? 32 : int'(m_ntap));
      for (int k = 0; k < nt; k++) begin
         if (n - k >= 0) begin
            a = m_h[k];
            b = m_hist[n-k];
            acc = acc + a * b;
         end
      end
      acc = acc >>> m_sh;
      if (m_sat && acc > LIM_HI) return 32'h7fffffff;
      if (m_sat && acc < LIM_LO) return 32'h80000000;
      return acc[31:0];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_h[i] = '0;
      m_ntap = 1; m_len = 0; m_sh = 0; m_sat = 0;
      m_hist.delete();
   endtask

   task automatic axi_write(input logic [11:0] a, input logic [31:0] d);
      bit aok, wok, ad, wd;
      @(posedge clk); #1;
      awvalid = 1; awaddr = a; wvalid = 1; wdata = d;
      ad = 0; wd = 0;
      for (int i = 0; i < 200 && !(ad && wd); i++) begin
         @(negedge clk);
         aok = awready; wok = wready;
         @(posedge clk); #1;
         if (aok && !ad) begin awvalid = 0; ad = 1; end
         if (wok && !wd) begin wvalid = 0; wd = 1; end
      end
      awvalid = 0; wvalid = 0;
      if (!(ad && wd)) tmo("axi_write");
   endtask

   task automatic axi_read(input logic [11:0] a, output logic [31:0] d);
      bit got;
      d = '0;
      @(posedge clk); #1;
      arvalid = 1; araddr = a;
      got = 0;
      for (int i = 0; i < 200 && !got; i++) begin @(negedge clk); got = arready; end
      @(posedge clk); #1;
      arvalid = 0;
      if (!got) begin tmo("axi_ar"); return; end
      rready = 1;
      got = 0;
      for (int i = 0; i < 200 && !got; i++) begin
         @(negedge clk);
         if (rvalid) begin got = 1; d = rdata; end
      end
      @(posedge clk); #1;
      rready = 0;
      if (!got) tmo("axi_r");
   endtask

   task automatic cfg(input logic [11:0] a, input logic [31:0] d);
      axi_write(a, d);
      if (a == 12'h010) m_len = d;
      else if (a == 12'h014) m_ntap = d;
      else if (a == 12'h018) begin m_sh = int'(d[5:0]); m_sat = d[8]; end
      else if (a >= 12'h080 && a < 12'h100) m_h[(a - 12'h080) >> 2] = d;
   endtask

   task automatic start_run();
      m_hist.delete(); rx.delete(); acc_q.delete(); rise_q.delete();
      axi_write(12'h000, 32'h1);
   endtask

   task automatic send_x(input logic [31:0] x, input bit last);
      bit got;
      beat_t b;
      m_hist.push_back(x);
      b.d = model_y();
      b.l = (32'(m_hist.size() - 1) == m_len - 32'd1) || last;
      expq.push_back(b);
      @(posedge clk); #1;
      ss_tvalid = 1; ss_tdata = x; ss_tlast = last;
      got = 0;
      for (int i = 0; i < 2000 && !got; i++) begin
         @(negedge clk);
         if (ss_tready) begin got = 1; acc_q.push_back(cyc); end
      end
      @(posedge clk); #1;
      ss_tvalid = 0; ss_tlast = 0;
      if (!got) tmo("ss_accept");
   endtask

   task automatic wait_drain();
      bit done;
      done = 0;
      for (int i = 0; i < 5000 && !done; i++) begin
         @(negedge clk);
         done = (expq.size() == 0);
      end
      if (!done) tmo("drain");
      repeat (3) @(posedge clk);
   endtask

   task automatic chk_reset_outs(input string nm);
      @(negedge clk);
      chk(nm, {25'd0, awready, wready, arready, rvalid, ss_tready, sm_tvalid, sm_tlast}, 32'h70);
      chk({nm, "_tdata"}, sm_tdata, 32'h0);
      chk({nm, "_rdata"}, rdata, 32'h0);
   endtask

   initial forever @(posedge clk) cyc++;

   initial forever begin
      @(posedge clk); #1;
      sm_tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // Output monitor: every accepted beat against the model, plus hold-while-stalled.
   initial begin
      bit stl, pv;
      logic [31:0] pd;
      logic pl;
      beat_t e;
      stl = 0; pv = 0; pd = '0; pl = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            stl = 0; pv = 0;
         end else begin
            if (ss_tready) xr_cnt++;
            if (stl) begin
               chk("hold_valid", {31'd0, sm_tvalid}, 32'd1);
               chk("hold_data", sm_tdata, pd);
               chk("hold_last", {31'd0, sm_tlast}, {31'd0, pl});
            end
            if (sm_tvalid && !pv) rise_q.push_back(cyc);
            if (sm_tvalid && sm_tready) begin
               if (expq.size() == 0) begin
                  checks++; errs++;
                  $display("FAIL extra_beat: got %h with no beat expected", sm_tdata);
               end else begin
                  e = expq.pop_front();
                  chk("y_data", sm_tdata, e.d);
                  chk("y_last", {31'd0, sm_tlast}, {31'd0, e.l});
               end
               rx.push_back(sm_tdata);
            end
            stl = sm_tvalid && !sm_tready;
            pd = sm_tdata; pl = sm_tlast; pv = sm_tvalid;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] v;
      logic [31:0] echo [4];
      int xr0;
      bit got;
      rst = 1; awvalid = 0; wvalid = 0; arvalid = 0; rready = 0;
      awaddr = '0; araddr = '0; wdata = '0;
      ss_tvalid = 0; ss_tdata = '0; ss_tlast = 0;
      model_reset();
      repeat (3) @(posedge clk);
      #1 rst = 0;
      chk_reset_outs("reset_outs");
      axi_read(12'h000, v); chk("reset_status", v, 32'h04);
      axi_read(12'h014, v); chk("reset_ntap", v, 32'd1);
      axi_read(12'h010, v); chk("reset_len", v, 32'd0);
      axi_read(12'h018, v); chk("reset_scale", v, 32'd0);
      axi_read(12'h094, v); chk("reset_tap5", v, 32'd0);
      axi_read(12'h040, v); chk("unmapped", v, 32'd0);

      // basic 11-tap run
      cfg(12'h014, 32'd11);
      for (int i = 0; i < 11; i++) cfg(12'(12'h080 + 4*i), 32'(i));
      cfg(12'h010, 32'd16);
      cfg(12'h018, 32'd0);
      axi_read(12'h09C, v); chk("tap7_rb", v, 32'd7);
      start_run();
      for (int i = 1; i <= 16; i++) send_x(32'(i), 0);
      wait_drain();
      chk("t1_count", 32'(rx.size()), 32'd16);
      if (rx.size() == 16) begin
         chk("t1_y0", rx[0], 32'd0);
         chk("t1_y1", rx[1], 32'd1);
         chk("t1_y15", rx[15], 32'd495);
      end
      if (acc_q.size() > 0 && rise_q.size() > 0) chk("latency", 32'(rise_q[0] - acc_q[0]), 32'd12);
      else tmo("latency");
      axi_read(12'h000, v); chk("t1_status1", v, 32'h06);
      axi_read(12'h000, v); chk("t1_status2", v, 32'h04);

      // same run under random backpressure
      rdy_rand = 1;
      start_run();
      for (int i = 1; i <= 16; i++) send_x(32'(i), 0);
      wait_drain();
      rdy_rand = 0;
      chk("bp_count", 32'(rx.size()), 32'd16);
      if (rx.size() == 16) chk("bp_y15", rx[15], 32'd495);
      axi_read(12'h000, v); chk("bp_status", v, 32'h06);

      // early tlast on the 4th sample of a 10-sample run
      cfg(12'h010, 32'd10);
      start_run();
      for (int i = 1; i <= 4; i++) send_x(32'(i), i == 4);
      wait_drain();
      chk("early_count", 32'(rx.size()), 32'd4);
      axi_read(12'h000, v); chk("early_status1", v, 32'h46);
      axi_read(12'h000, v); chk("early_status2", v, 32'h44);

      // tap and start writes while busy are dropped; reads still served
      cfg(12'h010, 32'd3);
      start_run();
      send_x(32'd5, 0);
      axi_write(12'h08C, 32'd999);
      axi_write(12'h000, 32'h1);
      axi_read(12'h010, v); chk("busy_len_rd", v, 32'd3);
      send_x(32'd6, 0);
      send_x(32'd7, 0);
      wait_drain();
      chk("busy_count", 32'(rx.size()), 32'd3);
      axi_read(12'h08C, v); chk("busy_tap3", v, 32'd3);
      axi_read(12'h000, v); chk("busy_status", v, 32'h06);

      // len = 0: straight to done, no stream traffic
      cfg(12'h010, 32'd0);
      xr0 = xr_cnt;
      start_run();
      got = 0;
      for (int i = 0; i < 4 && !got; i++) begin
         axi_read(12'h000, v);
         got = v[1];
      end
      if (got) chk("len0_status", v, 32'h06); else tmo("len0_done");
      chk("len0_no_xready", 32'(xr_cnt - xr0), 32'd0);
      chk("len0_no_beats", 32'(rx.size()), 32'd0);

      // saturation and shift
      cfg(12'h014, 32'd2);
      cfg(12'h080, 32'h7fffffff);
      cfg(12'h084, 32'h7fffffff);
      cfg(12'h018, 32'h100);
      cfg(12'h010, 32'd1);
      start_run();
      send_x(32'h7fffffff, 0);
      wait_drain();
      if (rx.size() == 1) chk("sat_hi", rx[0], 32'h7fffffff); else tmo("sat_hi");
      cfg(12'h018, 32'd31);
      cfg(12'h010, 32'd2);
      start_run();
      send_x(32'h7fffffff, 0);
      send_x(32'h7fffffff, 0);
      wait_drain();
      if (rx.size() == 2) begin
         chk("sh31_y0", rx[0], 32'h7ffffffe);
         chk("sh31_y1", rx[1], 32'hfffffffc);
      end else tmo("sh31");
      cfg(12'h018, 32'h100);
      cfg(12'h080, 32'h80000000);
      cfg(12'h010, 32'd1);
      start_run();
      send_x(32'h7fffffff, 0);
      wait_drain();
      if (rx.size() == 1) chk("sat_lo", rx[0], 32'h80000000); else tmo("sat_lo");

      // tap count 0 acts as 1; oversize count uses all 32 taps
      cfg(12'h018, 32'd0);
      cfg(12'h080, 32'd3);
      cfg(12'h014, 32'd0);
      axi_read(12'h014, v); chk("ntap0_rb", v, 32'd0);
      cfg(12'h010, 32'd2);
      start_run();
      send_x(32'd5, 0);
      send_x(32'd7, 0);
      wait_drain();
      if (rx.size() == 2) begin
         chk("ntap0_y0", rx[0], 32'd15);
         chk("ntap0_y1", rx[1], 32'd21);
      end else tmo("ntap0");
      cfg(12'h0FC, 32'd1000);
      cfg(12'h014, 32'd100);
      axi_read(12'h014, v); chk("ntap100_rb", v, 32'd100);
      cfg(12'h010, 32'd33);
      start_run();
      for (int i = 1; i <= 33; i++) send_x(32'(i), 0);
      wait_drain();
      if (rx.size() == 33) chk("clamp_y32", rx[32], 32'd3465); else tmo("clamp");

      // reset in the middle of a MAC sequence
      cfg(12'h014, 32'd11);
      cfg(12'h010, 32'd16);
      start_run();
      send_x(32'd9, 0);
      repeat (3) @(posedge clk);
      #1 rst = 1;
      @(posedge clk); #1 rst = 0;
      expq.delete();
      model_reset();
      chk_reset_outs("rst_outs");
      axi_read(12'h000, v); chk("rst_status", v, 32'h04);
      axi_read(12'h014, v); chk("rst_ntap", v, 32'd1);
      axi_read(12'h084, v); chk("rst_tap1", v, 32'd0);
      cfg(12'h080, 32'd1);
      cfg(12'h014, 32'd1);
      cfg(12'h010, 32'd4);
      echo[0] = 32'hfffffffb; echo[1] = 32'd123456; echo[2] = 32'h80000000; echo[3] = 32'd7;
      start_run();
      for (int i = 0; i < 4; i++) send_x(echo[i], 0);
      wait_drain();
      if (rx.size() == 4) begin
         for (int i = 0; i < 4; i++) chk("echo", rx[i], echo[i]);
      end else tmo("echo");

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
